// File: rtl/mips_pipe_pkg.sv
// Shared EX/MEM pipeline types: control bundle, default-width payload layout
// and helpers used by the pipeline-register stages.
package mips_pipe_pkg;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic zero;
    } ex_mem_ctrl_t;

    localparam ex_mem_ctrl_t CTRL_BUBBLE = '0;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_REG_AW = 5;

    // Default-width layout; stages with other widths declare the same field order locally.
    typedef struct packed {
        ex_mem_ctrl_t            ctrl;
        logic [PKG_DATA_W-1:0]   branch_dest;
        logic [PKG_DATA_W-1:0]   alu_result;
        logic [PKG_DATA_W-1:0]   write_data;
        logic [PKG_DATA_W-1:0]   instruction;
        logic [PKG_REG_AW-1:0]   write_reg;
    } ex_mem_payload_t;

    // Bubbles must never write registers/memory or redirect fetch; the
    // mux select and zero flag carry no side effect and pass through.
    function automatic ex_mem_ctrl_t qualify_ctrl(input ex_mem_ctrl_t c, input logic valid);
        ex_mem_ctrl_t q;
        q = c;
        if (!valid) begin
            q            = CTRL_BUBBLE;
            q.mem_to_reg = c.mem_to_reg;
            q.zero       = c.zero;
        end
        return q;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic one-entry-skid valid/ready register: full throughput with a fully
// registered upstream ready, plus synchronous flush of both entries.
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_reg;
    logic [W-1:0] main_data_reg;
    logic         skid_valid_reg;
    logic [W-1:0] skid_data_reg;
    logic         acc;
    logic         adv;

    assign in_ready  = ~skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

    assign acc = in_valid & ~skid_valid_reg;
    assign adv = out_ready | ~main_valid_reg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (adv) begin
            if (skid_valid_reg) begin
                main_valid_reg <= 1'b1;
                main_data_reg  <= skid_data_reg;
                skid_valid_reg <= acc;
                if (acc) begin
                    skid_data_reg <= in_data;
                end
            end else begin
                main_valid_reg <= acc;
                main_data_reg  <= in_data;
            end
        end else if (acc) begin
            // Downstream stalled: park the new entry so ready can stay registered.
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_stage_hs.sv
// EX/MEM pipeline register with valid/ready skid buffering, flush, bubble-safe
// control outputs, branch-taken decode and a saturating stall counter.
module ex_mem_stage_hs
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              RegWrite_EX,
    input  logic              MemtoReg_EX,
    input  logic              Branch_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              Zero_EX,
    input  logic [DATA_W-1:0] Branch_Dest_EX,
    input  logic [DATA_W-1:0] ALU_Result_EX,
    input  logic [DATA_W-1:0] Read_Data_2_EX,
    input  logic [DATA_W-1:0] Instruction_EX,
    input  logic [REG_AW-1:0] Write_Register_EX,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              RegWrite_MEM,
    output logic              MemtoReg_MEM,
    output logic              Branch_MEM,
    output logic              MemRead_MEM,
    output logic              MemWrite_MEM,
    output logic              Zero_MEM,
    output logic [DATA_W-1:0] Branch_Dest_MEM,
    output logic [DATA_W-1:0] ALU_Result_MEM,
    output logic [DATA_W-1:0] Write_Data_MEM,
    output logic [DATA_W-1:0] Instruction_MEM,
    output logic [REG_AW-1:0] Write_Register_MEM,
    output logic              Branch_Taken_MEM,
    input  logic              Stall_Clr,
    output logic [CNT_W-1:0]  Stall_Count
);

    typedef struct packed {
        ex_mem_ctrl_t        ctrl;
        logic [DATA_W-1:0]   branch_dest;
        logic [DATA_W-1:0]   alu_result;
        logic [DATA_W-1:0]   write_data;
        logic [DATA_W-1:0]   instruction;
        logic [REG_AW-1:0]   write_reg;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t     in_payload;
    payload_t     main_payload;
    logic [PW-1:0] in_vec;
    logic [PW-1:0] main_vec;
    logic          main_valid;
    ex_mem_ctrl_t  ctrl_q;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    always_comb begin
        in_payload                 = '0;
        in_payload.ctrl.reg_write  = RegWrite_EX;
        in_payload.ctrl.mem_to_reg = MemtoReg_EX;
        in_payload.ctrl.branch     = Branch_EX;
        in_payload.ctrl.mem_read   = MemRead_EX;
        in_payload.ctrl.mem_write  = MemWrite_EX;
        in_payload.ctrl.zero       = Zero_EX;
        in_payload.branch_dest     = Branch_Dest_EX;
        in_payload.alu_result      = ALU_Result_EX;
        in_payload.write_data      = Read_Data_2_EX;
        in_payload.instruction     = Instruction_EX;
        in_payload.write_reg       = Write_Register_EX;
    end

    assign in_vec       = in_payload;
    assign main_payload = payload_t'(main_vec);

    pipe_skid_reg #(.W(PW)) u_skid (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .flush     (Flush),
        .in_valid  (In_Valid),
        .in_ready  (In_Ready),
        .in_data   (in_vec),
        .out_valid (main_valid),
        .out_ready (Out_Ready),
        .out_data  (main_vec)
    );

    assign ctrl_q = qualify_ctrl(main_payload.ctrl, main_valid);

    assign Out_Valid          = main_valid;
    assign RegWrite_MEM       = ctrl_q.reg_write;
    assign MemtoReg_MEM       = ctrl_q.mem_to_reg;
    assign Branch_MEM         = ctrl_q.branch;
    assign MemRead_MEM        = ctrl_q.mem_read;
    assign MemWrite_MEM       = ctrl_q.mem_write;
    assign Zero_MEM           = ctrl_q.zero;
    assign Branch_Dest_MEM    = main_payload.branch_dest;
    assign ALU_Result_MEM     = main_payload.alu_result;
    assign Write_Data_MEM     = main_payload.write_data;
    assign Instruction_MEM    = main_payload.instruction;
    assign Write_Register_MEM = main_payload.write_reg;
    assign Branch_Taken_MEM   = main_valid & ctrl_q.branch & ctrl_q.zero;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (Stall_Clr) begin
            stall_cnt_next = '0;
        end else if (main_valid && !Out_Ready && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign Stall_Count = stall_cnt_reg;

endmodule
